// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared sizes, types and write-priority helper for regfile_mp_sb
package rf_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = $clog2(NREGS_DEF);
   localparam int NWP_MAX   = 8;
   localparam int AW_MAX    = 8;
   localparam int PW        = $clog2(NWP_MAX);

   typedef struct packed {
      logic          hit;
      logic [PW-1:0] port;
   } prio_t;

   // Ascending scan, so the highest-numbered matching write port is the one returned.
   function automatic prio_t prio_hit(
      input logic [AW_MAX-1:0]              addr,
      input logic [NWP_MAX-1:0]             wr_en,
      input logic [NWP_MAX-1:0][AW_MAX-1:0] wr_addr
   );
      prio_t r;
      r = '0;
      for (int w = 0; w < NWP_MAX; w++) begin
         if (wr_en[w] && wr_addr[w] == addr) begin
            r.hit  = 1'b1;
            r.port = PW'(w);
         end
      end
      return r;
   endfunction
endpackage

// File: rtl/regfile_mp_sb_if.sv
// rtl/regfile_mp_sb_if.sv - read/write/issue bus between the core pipeline and regfile_mp_sb
interface regfile_mp_sb_if
   import rf_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRP   = 2,
   parameter int NWP   = 2
);
   localparam int AW = $clog2(NREGS);

   logic [NRP*AW-1:0]   rr_addr;
   logic [NRP*XLEN-1:0] rd_data;
   logic [NRP-1:0]      rd_busy;
   logic [NWP-1:0]      wr_en;
   logic [NWP*AW-1:0]   wr_addr;
   logic [NWP*XLEN-1:0] wr_data;
   logic                iss_en;
   logic [AW-1:0]       iss_rd;
   logic [NREGS-1:0]    busy_vec;
   logic                wr_collide;

   modport master (
      output rr_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
      input  rd_data, rd_busy, busy_vec, wr_collide
   );

   modport slave (
      input  rr_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
      output rd_data, rd_busy, busy_vec, wr_collide
   );
endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits: issue sets, writeback clears, read-port lookup
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int NREGS   = NREGS_DEF,
   parameter int NRP     = 2,
   parameter int NWP     = 2,
   parameter bit BYPASS  = 1'b1,
   parameter bit ZERO_X0 = 1'b1,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              iss_en,
   input  logic [AW-1:0]     iss_rd,
   input  logic [NWP-1:0]    wr_en,
   input  logic [NWP*AW-1:0] wr_addr,
   input  logic [NRP*AW-1:0] rr_addr,
   output logic [NRP-1:0]    rd_busy,
   output logic [NREGS-1:0]  busy_vec
);
   logic [NREGS-1:0] set_v;
   logic [NREGS-1:0] clr_v;
   logic [NREGS-1:0] busy_d;

   // A same-cycle issue beats writeback: the new producer owns the register.
   always_comb begin
      set_v = '0;
      clr_v = '0;
      for (int r = 0; r < NREGS; r++) begin
         set_v[r] = iss_en && (iss_rd == AW'(r));
         for (int w = 0; w < NWP; w++) begin
            if (wr_en[w] && wr_addr[w*AW +: AW] == AW'(r)) clr_v[r] = 1'b1;
         end
      end
      busy_d = set_v | (busy_vec & ~clr_v);
      if (ZERO_X0) busy_d[0] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) busy_vec <= '0;
      else          busy_vec <= busy_d;
   end

   always_comb begin
      logic [AW-1:0] ra;
      ra      = '0;
      rd_busy = '0;
      for (int p = 0; p < NRP; p++) begin
         ra         = rr_addr[p*AW +: AW];
         rd_busy[p] = busy_vec[ra];
         if (BYPASS && clr_v[ra] && !set_v[ra]) rd_busy[p] = 1'b0;
      end
   end
endmodule

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port integer register file with x0, write bypass and busy scoreboard
module regfile_mp_sb
   import rf_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int NREGS   = NREGS_DEF,
   parameter int NRP     = 2,
   parameter int NWP     = 2,
   parameter bit BYPASS  = 1'b1,
   parameter bit ZERO_X0 = 1'b1
) (
   input logic            clock,
   input logic            reset_n,
   regfile_mp_sb_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]                rf [NREGS];
   logic [NWP_MAX-1:0]             wen_pad;
   logic [NWP_MAX-1:0][AW_MAX-1:0] wad_pad;
   logic                           coll_next;
   logic                           coll_q;

   always_comb begin
      wen_pad = '0;
      wad_pad = '0;
      for (int w = 0; w < NWP; w++) begin
         wen_pad[w] = bus.wr_en[w];
         wad_pad[w] = AW_MAX'(bus.wr_addr[w*AW +: AW]);
      end
   end

   // Ports are applied in ascending order so the last (highest) write to an address sticks.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NREGS; r++) rf[r] <= '0;
      end else begin
         for (int w = 0; w < NWP; w++) begin
            if (bus.wr_en[w] && !(ZERO_X0 && bus.wr_addr[w*AW +: AW] == '0))
               rf[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      logic [AW-1:0]   ra;
      prio_t           ph;
      logic [XLEN-1:0] d;
      ra          = '0;
      ph          = '0;
      d           = '0;
      bus.rd_data = '0;
      for (int p = 0; p < NRP; p++) begin
         ra = bus.rr_addr[p*AW +: AW];
         ph = prio_hit(AW_MAX'(ra), wen_pad, wad_pad);
         d  = rf[ra];
         if (BYPASS && ph.hit) d = bus.wr_data[ph.port*XLEN +: XLEN];
         if (!reset_n || (ZERO_X0 && ra == '0)) d = '0;
         bus.rd_data[p*XLEN +: XLEN] = d;
      end
   end

   always_comb begin
      coll_next = 1'b0;
      for (int i = 0; i < NWP; i++) begin
         for (int j = i + 1; j < NWP; j++) begin
            if (wen_pad[i] && wen_pad[j] && wad_pad[i] == wad_pad[j] &&
                !(ZERO_X0 && wad_pad[i] == '0))
               coll_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) coll_q <= 1'b0;
      else          coll_q <= coll_next;
   end

   assign bus.wr_collide = coll_q;

   rf_scoreboard #(
      .NREGS   (NREGS),
      .NRP     (NRP),
      .NWP     (NWP),
      .BYPASS  (BYPASS),
      .ZERO_X0 (ZERO_X0)
   ) u_sb (
      .clock    (clock),
      .reset_n  (reset_n),
      .iss_en   (bus.iss_en),
      .iss_rd   (bus.iss_rd),
      .wr_en    (bus.wr_en),
      .wr_addr  (bus.wr_addr),
      .rr_addr  (bus.rr_addr),
      .rd_busy  (bus.rd_busy),
      .busy_vec (bus.busy_vec)
   );
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - bench for regfile_mp_sb with bypass and non-bypass instances
module tb_regfile_mp_sb;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRP   = 3;
   localparam int NWP   = 2;
   localparam int AW    = 5;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   regfile_mp_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP)) ifa ();
   regfile_mp_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP)) ifb ();

   regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP), .BYPASS(1'b1), .ZERO_X0(1'b1))
      dut_byp (.clock(clock), .reset_n(reset_n), .bus(ifa));
   regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP), .BYPASS(1'b0), .ZERO_X0(1'b1))
      dut_nob (.clock(clock), .reset_n(reset_n), .bus(ifb));

   assign ifb.rr_addr = ifa.rr_addr;
   assign ifb.wr_en   = ifa.wr_en;
   assign ifb.wr_addr = ifa.wr_addr;
   assign ifb.wr_data = ifa.wr_data;
   assign ifb.iss_en  = ifa.iss_en;
   assign ifb.iss_rd  = ifa.iss_rd;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];
   int tests = 0;
   int fails = 0;

   logic [XLEN-1:0]  m_rf [NREGS];
   logic [NREGS-1:0] m_busy;
   logic             m_coll;

   logic [AW-1:0]   rr [NRP];
   logic            we [NWP];
   logic [AW-1:0]   wa [NWP];
   logic [XLEN-1:0] wd [NWP];
   logic            iss;
   logic [AW-1:0]   ird;

   task automatic push(input string t, input logic [31:0] v);
      sb.push_back('{tag: t, val: v});
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $error("FAIL sb_empty: observed %0h with no expected entry", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic idle();
      for (int w = 0; w < NWP; w++) begin we[w] = 1'b0; wa[w] = '0; wd[w] = '0; end
      iss = 1'b0;
      ird = '0;
   endtask

   task automatic m_reset();
      for (int r = 0; r < NREGS; r++) m_rf[r] = '0;
      m_busy = '0;
      m_coll = 1'b0;
   endtask

   function automatic logic [31:0] m_read(input int p, input bit byp);
      logic [31:0] v;
      if (rr[p] == '0) return 32'h0;
      v = m_rf[rr[p]];
      if (byp) for (int w = 0; w < NWP; w++) if (we[w] && wa[w] == rr[p]) v = wd[w];
      return v;
   endfunction

   function automatic logic m_rbusy(input int p, input bit byp);
      logic b;
      b = m_busy[rr[p]];
      if (byp && !(iss && ird == rr[p]))
         for (int w = 0; w < NWP; w++) if (we[w] && wa[w] == rr[p]) b = 1'b0;
      return b;
   endfunction

   task automatic drive();
      @(negedge clock);
      ifa.rr_addr = {rr[2], rr[1], rr[0]};
      ifa.wr_en   = {we[1], we[0]};
      ifa.wr_addr = {wa[1], wa[0]};
      ifa.wr_data = {wd[1], wd[0]};
      ifa.iss_en  = iss;
      ifa.iss_rd  = ird;
   endtask

   task automatic comb_phase();
      #1;
      for (int p = 0; p < NRP; p++) begin
         push("rd_data_byp", m_read(p, 1'b1));   check(ifa.rd_data[p*XLEN +: XLEN]);
         push("rd_data_nob", m_read(p, 1'b0));   check(ifb.rd_data[p*XLEN +: XLEN]);
         push("rd_busy_byp", 32'(m_rbusy(p, 1'b1))); check(32'(ifa.rd_busy[p]));
         push("rd_busy_nob", 32'(m_rbusy(p, 1'b0))); check(32'(ifb.rd_busy[p]));
      end
   endtask

   task automatic edge_phase();
      logic [NREGS-1:0] nb;
      @(posedge clock);
      nb = m_busy;
      for (int r = 0; r < NREGS; r++) begin
         if (iss && ird == AW'(r)) nb[r] = 1'b1;
         else for (int w = 0; w < NWP; w++) if (we[w] && wa[w] == AW'(r)) nb[r] = 1'b0;
      end
      nb[0]  = 1'b0;
      m_busy = nb;
      for (int w = 0; w < NWP; w++) if (we[w] && wa[w] != '0) m_rf[wa[w]] = wd[w];
      m_coll = we[0] && we[1] && wa[0] == wa[1] && wa[0] != '0;
      #1;
      push("busy_vec_byp", m_busy);       check(ifa.busy_vec);
      push("busy_vec_nob", m_busy);       check(ifb.busy_vec);
      push("collide_byp", 32'(m_coll));   check(32'(ifa.wr_collide));
      push("collide_nob", 32'(m_coll));   check(32'(ifb.wr_collide));
   endtask

   task automatic cycle();
      drive(); comb_phase(); edge_phase();
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
   endfunction

   initial begin
      m_reset();
      idle();
      for (int p = 0; p < NRP; p++) rr[p] = 5'd5;
      drive();
      #1;
      push("reset_rd0", 32'h0);  check(ifa.rd_data[31:0]);
      push("reset_busy", 32'h0); check(ifa.busy_vec);
      push("reset_coll", 32'h0); check(32'(ifa.wr_collide));
      reset_n = 1'b1;
      edge_phase();

      // x0: write and issue are both dropped
      idle(); rr[0] = 5'd0; we[1] = 1'b1; wa[1] = 5'd0; wd[1] = 32'h1234; iss = 1'b1; ird = 5'd0;
      drive(); comb_phase();
      push("x0_rd", 32'h0); check(ifa.rd_data[31:0]);
      edge_phase();
      push("x0_busy", 32'h0); check(32'(ifa.busy_vec[0]));

      // both ports write x7; port 1 wins
      idle(); rr[0] = 5'd7; we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h1; we[1] = 1'b1; wa[1] = 5'd7; wd[1] = 32'h2;
      drive(); comb_phase();
      push("prio_byp_rd", 32'h2); check(ifa.rd_data[31:0]);
      push("prio_nob_rd", 32'h0); check(ifb.rd_data[31:0]);
      edge_phase();
      push("prio_coll_hi", 32'h1); check(32'(ifa.wr_collide));
      idle(); rr[0] = 5'd7;
      drive(); comb_phase();
      push("prio_rf_x7", 32'h2); check(ifa.rd_data[31:0]);
      edge_phase();
      push("prio_coll_lo", 32'h0); check(32'(ifa.wr_collide));

      // bypass versus stored value
      idle(); we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h1111;
      cycle();
      idle(); rr[1] = 5'd3; we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'hA5A5;
      drive(); comb_phase();
      push("byp_new", 32'hA5A5); check(ifa.rd_data[63:32]);
      push("nob_old", 32'h1111); check(ifb.rd_data[63:32]);
      edge_phase();

      // scoreboard set / issue-beats-writeback / clear
      idle(); iss = 1'b1; ird = 5'd9;
      cycle();
      push("sb_issue", 32'h1); check(32'(ifa.busy_vec[9]));
      idle(); we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h99; iss = 1'b1; ird = 5'd9;
      cycle();
      push("sb_iss_wb", 32'h1); check(32'(ifa.busy_vec[9]));
      idle(); rr[2] = 5'd9; we[1] = 1'b1; wa[1] = 5'd9; wd[1] = 32'h9A;
      drive(); comb_phase();
      push("sb_rdbusy_byp", 32'h0); check(32'(ifa.rd_busy[2]));
      push("sb_rdbusy_nob", 32'h1); check(32'(ifb.rd_busy[2]));
      edge_phase();
      push("sb_wb_clear", 32'h0); check(32'(ifa.busy_vec[9]));

      // asynchronous reset in the middle of a cycle
      idle(); we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEAD_BEEF; iss = 1'b1; ird = 5'd5;
      cycle();
      idle(); for (int p = 0; p < NRP; p++) rr[p] = 5'd5;
      drive(); comb_phase();
      #1;
      reset_n = 1'b0;
      #1;
      m_reset();
      for (int p = 0; p < NRP; p++) begin
         push("async_rst_rd", 32'h0); check(ifa.rd_data[p*XLEN +: XLEN]);
      end
      push("async_rst_busy", 32'h0); check(ifa.busy_vec);
      reset_n = 1'b1;
      edge_phase();

      for (int n = 0; n < 10000; n++) begin
         for (int p = 0; p < NRP; p++) rr[p] = rnd_addr();
         for (int w = 0; w < NWP; w++) begin
            we[w] = 1'($urandom_range(0, 1));
            wa[w] = rnd_addr();
            wd[w] = $urandom;
         end
         iss = 1'($urandom_range(0, 1));
         ird = rnd_addr();
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
